// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and transmitter signal bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        gnt;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_busy;
    logic [OWN_W-1:0]          owner;
    logic                      active;
    logic                      err_timeout;

    // arbiter side
    modport master (
        input  req, req_data, req_lock, tx_busy,
        output gnt, tx_start, tx_data, owner, active, err_timeout
    );

    // requesters and transmitter side
    modport slave (
        output req, req_data, req_lock, tx_busy,
        input  gnt, tx_start, tx_data, owner, active, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter; optional burst lock under UART_ARB_LOCK_EN
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.master bus
);
    localparam int OWN_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam logic [3:0] TIMEOUT = 4'(BUSY_TIMEOUT);

    logic [1:0]         state;
    logic [3:0]         cnt;
    logic [OWN_W-1:0]   owner_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               tx_start_q;
    logic [DATA_W-1:0]  tx_data_q;
    logic               active_q;
    logic               err_q;

    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [OWN_W-1:0]   win_idx;
    logic [OWN_W-1:0]   cand;

    assign bus.gnt         = gnt_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.owner       = owner_q;
    assign bus.active      = active_q;
    assign bus.err_timeout = err_q;

`ifdef UART_ARB_LOCK_EN
    // a locked owner keeps the transmitter: nobody else may win, even while it is not requesting
    always_comb begin
        eligible = bus.req;
        if (bus.req_lock[owner_q]) begin
            eligible = bus.req & (NUM_REQ'(1) << owner_q);
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;

    // every request competes on every frame
    always_comb begin
        eligible = bus.req;
    end
`endif

    // rotating search starting just after the last owner
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = OWN_W'((int'(owner_q) + i) % NUM_REQ);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // frame sequencing: grant, wait for busy to rise (bounded), wait for busy to fall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            owner_q    <= OWN_W'(NUM_REQ - 1);
            gnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            active_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            gnt_q      <= '0;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!bus.tx_busy && win_found) begin
                        gnt_q      <= NUM_REQ'(1) << win_idx;
                        tx_start_q <= 1'b1;
                        tx_data_q  <= bus.req_data[win_idx*DATA_W +: DATA_W];
                        owner_q    <= win_idx;
                        active_q   <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (cnt >= TIMEOUT) begin
                        // transmitter never picked the byte up; drop it rather than retry
                        err_q    <= 1'b1;
                        active_q <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (cnt != 4'hF) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        active_q <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    active_q <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    int       m_owner;
    logic [7:0] m_bytes [4];
    int       order [$];

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .BUSY_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] b);
        bus.req[i]            = 1'b1;
        bus.req_data[i*8 +: 8] = b;
        m_bytes[i]            = b;
    endtask

    // winner = pending requester at the smallest rotational distance past the last owner
    function automatic int rr_pick();
        int best;
        int bestd;
        best  = -1;
        bestd = 99;
`ifdef UART_ARB_LOCK_EN
        if (bus.req_lock[m_owner]) return bus.req[m_owner] ? m_owner : -1;
`endif
        for (int i = 0; i < 4; i++) begin
            if (bus.req[i]) begin
                int d;
                d = (i - m_owner - 1 + 4) % 4;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic wait_gnt();
        int w;
        w = 0;
        while (bus.gnt == 4'b0 && w < 30) begin
            @(negedge clk);
            w++;
        end
        chk("gnt_seen", 32'(bus.gnt != 4'b0), 1);
    endtask

    task automatic serve(input int exp, input bit keep, input bit unlock, input int busy_cyc);
        wait_gnt();
        chk("gnt", 32'(bus.gnt), 32'(1) << exp);
        chk("tx_start", 32'(bus.tx_start), 1);
        chk("tx_data", 32'(bus.tx_data), 32'(m_bytes[exp]));
        chk("owner", 32'(bus.owner), exp);
        chk("active_grant", 32'(bus.active), 1);
        for (int i = 0; i < 4; i++) if (bus.gnt[i]) order.push_back(i);
        m_owner = exp;
        if (keep) set_req(exp, 8'($urandom));
        else bus.req[exp] = 1'b0;
        if (unlock) bus.req_lock[exp] = 1'b0;
        bus.tx_busy = 1'b1;
        @(negedge clk);
        chk("gnt_pulse", 32'(bus.gnt), 0);
        chk("tx_start_pulse", 32'(bus.tx_start), 0);
        chk("active_frame", 32'(bus.active), 1);
        repeat (busy_cyc) begin
            @(negedge clk);
            chk("gnt_busy", 32'(bus.gnt), 0);
        end
        bus.tx_busy = 1'b0;
        @(negedge clk);
        chk("active_done", 32'(bus.active), 0);
        chk("gnt_gap", 32'(bus.gnt), 0);
    endtask

    initial begin
        int exp;
        int idx;
        int cyc;
        int sent1;
        bit keep;
        bit unlock;

        bus.req      = '0;
        bus.req_data = '0;
        bus.req_lock = '0;
        bus.tx_busy  = 1'b0;
        m_owner      = 3;
        for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_tx_start", 32'(bus.tx_start), 0);
        chk("rst_tx_data", 32'(bus.tx_data), 0);
        chk("rst_active", 32'(bus.active), 0);
        chk("rst_err", 32'(bus.err_timeout), 0);
        chk("rst_owner", 32'(bus.owner), 3);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_req_gnt", 32'(bus.gnt), 0);

        // single request with exact one-cycle latency
        set_req(0, 8'hA5);
        @(negedge clk);
        chk("latency_gnt", 32'(bus.gnt), 1);
        serve(0, 1'b0, 1'b0, 2);

        // all four held from reset: full rotation and wrap
        rst = 1'b0;
        m_owner = 3;
        for (int i = 0; i < 4; i++) set_req(i, 8'($urandom));
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) serve(rr_pick(), 1'b1, 1'b0, $urandom_range(0, 3));
        bus.req = '0;

        // busy already high blocks grants; requester 1 withdraws
        bus.tx_busy = 1'b1;
        set_req(1, 8'($urandom));
        set_req(2, 8'($urandom));
        repeat (3) begin
            @(negedge clk);
            chk("busy_block_gnt", 32'(bus.gnt), 0);
        end
        bus.req[1]  = 1'b0;
        bus.tx_busy = 1'b0;
        serve(rr_pick(), 1'b0, 1'b0, 1);
        set_req(0, 8'($urandom));
        set_req(2, 8'($urandom));
        serve(rr_pick(), 1'b0, 1'b0, 1);
        serve(rr_pick(), 1'b0, 1'b0, 1);

        // randomized traffic against the rotational-distance model
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < 4; i++)
                if (!bus.req[i] && $urandom_range(0, 1) == 1) set_req(i, 8'($urandom));
            if (bus.req == 4'b0) set_req($urandom_range(0, 3), 8'($urandom));
            serve(rr_pick(), 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 5));
        end
        bus.req = '0;

        // reset in the middle of a frame
        set_req(1, 8'($urandom));
        wait_gnt();
        bus.req[1]  = 1'b0;
        bus.tx_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt), 0);
        chk("mid_rst_tx_start", 32'(bus.tx_start), 0);
        chk("mid_rst_tx_data", 32'(bus.tx_data), 0);
        chk("mid_rst_active", 32'(bus.active), 0);
        chk("mid_rst_err", 32'(bus.err_timeout), 0);
        chk("mid_rst_owner", 32'(bus.owner), 3);
        @(negedge clk);
        rst = 1'b1;
        bus.tx_busy = 1'b0;
        m_owner = 3;
        set_req(3, 8'($urandom));
        serve(rr_pick(), 1'b0, 1'b0, 1);

        // transmitter never responds: timeout after BUSY_TIMEOUT+1 cycles
        idx = $urandom_range(0, 3);
        set_req(idx, 8'($urandom));
        wait_gnt();
        chk("to_gnt", 32'(bus.gnt), 32'(1) << idx);
        m_owner = idx;
        bus.req[idx] = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.err_timeout && cyc < 20);
        chk("to_cycles", cyc, 5);
        chk("to_err", 32'(bus.err_timeout), 1);
        chk("to_active", 32'(bus.active), 0);
        @(negedge clk);
        chk("to_err_pulse", 32'(bus.err_timeout), 0);
        set_req($urandom_range(0, 3), 8'($urandom));
        serve(rr_pick(), 1'b0, 1'b0, 2);

        // burst lock: requester 1 sends three bytes while requester 0 waits
        set_req(0, 8'($urandom));
        serve(rr_pick(), 1'b0, 1'b0, 1);
        order.delete();
        set_req(0, 8'($urandom));
        set_req(1, 8'($urandom));
        bus.req_lock[1] = 1'b1;
        sent1 = 0;
        for (int g = 0; g < 10 && sent1 < 3; g++) begin
            exp = rr_pick();
            keep = 1'b1;
            unlock = 1'b0;
            if (exp == 1) begin
                sent1++;
                keep   = (sent1 < 3);
                unlock = (sent1 == 3);
            end
            serve(exp, keep, unlock, 1);
        end
        bus.req_lock = '0;
        serve(rr_pick(), 1'b0, 1'b0, 1);
        chk("lock_order_len", 32'(order.size() >= 4), 1);
`ifdef UART_ARB_LOCK_EN
        chk("lock_order0", order[0], 1);
        chk("lock_order1", order[1], 1);
        chk("lock_order2", order[2], 1);
        chk("lock_order3", order[3], 0);
`else
        chk("lock_order0", order[0], 1);
        chk("lock_order1", order[1], 0);
        chk("lock_order2", order[2], 1);
        chk("lock_order3", order[3], 0);
`endif
        bus.req = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter among `NUM_REQ` byte-producing requesters. Each requester presents a byte and holds a request until it receives a one-cycle grant. The arbiter then drives the transmitter's `tx_start`/`tx_data` pair and tracks `tx_busy` until the frame completes. It sits between client logic (command responder, debug printer, status reporter) and the UART top level.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 8: byte width; must match the transmitter data width.
- `BUSY_TIMEOUT`, 4: cycles to wait for `tx_busy` rise after `tx_start`, range 1..15.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester byte request (level).
- `req_data`  in  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W].
- `req_lock`  in  NUM_REQ  burst lock; used only with `UART_ARB_LOCK_EN`.
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  DATA_W  registered byte to the transmitter.
- `tx_busy`  in  1  transmitter busy flag.
- `owner`  out  clog2(NUM_REQ)  index of the last granted requester.
- `active`  out  1  high from grant until the frame is done.
- `err_timeout`  out  1  one-cycle pulse: `tx_busy` never rose.

## Operation
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- **IDLE:**
  - If `tx_busy`=0 and any eligible `req` is high, pick the winner. The search starts at `owner`+1 and wraps modulo NUM_REQ.
  - Registered outputs on the next edge: `gnt[win]`=1, `tx_start`=1, `tx_data`=`req_data[win]`, `owner`=win, `active`=1.
  - State moves to WAIT_BUSY and the timeout counter clears.
- **WAIT_BUSY:**
  - `req` is not sampled in this state.
  - `tx_busy`=1 moves the FSM to WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches `BUSY_TIMEOUT`: pulse `err_timeout`, drop `active`, go to IDLE. The byte is lost and is not re-granted.
- **WAIT_DONE:** `tx_busy`=0 drops `active` and returns the FSM to IDLE.
- **Requester rules:**
  - Hold `req` and `req_data` stable until `gnt` is seen.
  - A requester may drop `req` before `gnt`; this withdraws the request with no side effects.
  - It may present a new byte in the cycle after `gnt`.
- **Boundary cases:**
  - `tx_busy` already high in IDLE: no grant; wait.
  - All `req` low: remain in IDLE, no outputs.
  - Single requester: it is re-granted every frame.
  - Counter width is 4 bits and saturates.
- **Reset (asynchronous, `rst`=0), at any time including mid-frame:**
  - State → IDLE.
  - `gnt`=0, `tx_start`=0, `tx_data`=0, `active`=0, `err_timeout`=0.
  - `owner`=NUM_REQ-1, so requester 0 has first priority.

## Timing
- Grant latency: `req` high in IDLE at edge N gives `gnt`/`tx_start` high after edge N+1, for exactly one cycle.
- `tx_data` holds the granted byte from the `tx_start` cycle until the next grant.
- Back-to-back: the next grant comes no earlier than 1 cycle after the IDLE return, i.e. ≥2 cycles after `tx_busy` falls.
- Timeout: `err_timeout` asserts BUSY_TIMEOUT+1 cycles after `tx_start` if `tx_busy` stays low.

## Configuration
- `UART_ARB_LOCK_EN` defined:
  - In IDLE, if `req_lock[owner]`=1, only `owner` is eligible. Other requests wait, even if `owner` has no `req`.
  - The lock is released when `req_lock[owner]` falls; normal round-robin resumes from `owner`+1.
- `UART_ARB_LOCK_EN` undefined: `req_lock` is ignored and pure round-robin applies on every frame.

## Test plan
- Single request: `req`=0001, `req_data[0]`=0xA5.
  - Expect `gnt`=0001 and `tx_start` one cycle later with `tx_data`=0xA5.
  - Expect `active` to fall after `tx_busy` falls.
- Simultaneous requests: `req`=1111 held from reset.
  - Expect grant order 0,1,2,3,0.
  - Expect each next grant only after `tx_busy` falls.
- Withdraw and fairness: `req`=0110, requester 1 drops `req` before its grant.
  - Expect requester 2 granted next with no `gnt[1]`.
  - Then, after `owner`=2, `req`=0101 must grant 0 before 2.
- Reset mid-frame: assert `rst`=0 during WAIT_DONE.
  - Expect all outputs 0 immediately and `owner`=3.
  - After release with `req`=1000, expect requester 3 granted.
- Timeout: tie `tx_busy`=0 and grant one byte.
  - Expect `err_timeout` pulse exactly BUSY_TIMEOUT+1=5 cycles after `tx_start`, with `active`=0.
  - Expect the next request to be granted normally.
- Lock (`UART_ARB_LOCK_EN`): requester 1 sends 3 bytes with `req_lock[1]`=1 while `req[0]`=1.
  - Expect grants 1,1,1, then 0 after the lock drops.
  - Without the macro, expect 1,0,1,0 instead.
